// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite widths, response codes and decoder FSM state types.
package axi4lite_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_FWD,
    WR_RESP,
    WR_ERR
  } axi_dec_wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA,
    RD_ERR
  } axi_dec_rd_state_e;

endpackage

// File: rtl/axi4lite_addr_decode.sv
// Combinational base/mask address decoder; lowest matching index wins.
module axi4lite_addr_decode
  import axi4lite_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = 2,
  parameter logic [NUM_SLAVES-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_MASK =
    {4{32'hF000_0000}}
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  output logic [SEL_W-1:0]          sel,
  output logic                      hit
);

  // Scan from the top index down so the lowest matching index overrides.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i]) == SLAVE_BASE[i]) begin
        sel = SEL_W'(i);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4lite_decoder.sv
// 1-to-N AXI4-Lite decoder: independent read/write FSMs, one outstanding
// transaction per path, unmapped addresses answered locally with DECERR.
module axi4lite_decoder
  import axi4lite_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES-1:0][AXI_ADDR_WIDTH-1:0] SLAVE_MASK =
    {4{32'hF000_0000}}
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]                     s_axi_awaddr,
  input  logic                                          s_axi_awvalid,
  output logic                                          s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]                     s_axi_wdata,
  input  logic [AXI_STRB_WIDTH-1:0]                     s_axi_wstrb,
  input  logic                                          s_axi_wvalid,
  output logic                                          s_axi_wready,
  output logic [1:0]                                    s_axi_bresp,
  output logic                                          s_axi_bvalid,
  input  logic                                          s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]                     s_axi_araddr,
  input  logic                                          s_axi_arvalid,
  output logic                                          s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]                     s_axi_rdata,
  output logic [1:0]                                    s_axi_rresp,
  output logic                                          s_axi_rvalid,
  input  logic                                          s_axi_rready,
  output logic [NUM_SLAVES-1:0][AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [NUM_SLAVES-1:0]                         m_axi_awvalid,
  input  logic [NUM_SLAVES-1:0]                         m_axi_awready,
  output logic [NUM_SLAVES-1:0][AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [NUM_SLAVES-1:0][AXI_STRB_WIDTH-1:0]     m_axi_wstrb,
  output logic [NUM_SLAVES-1:0]                         m_axi_wvalid,
  input  logic [NUM_SLAVES-1:0]                         m_axi_wready,
  input  logic [NUM_SLAVES-1:0][1:0]                    m_axi_bresp,
  input  logic [NUM_SLAVES-1:0]                         m_axi_bvalid,
  output logic [NUM_SLAVES-1:0]                         m_axi_bready,
  output logic [NUM_SLAVES-1:0][AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [NUM_SLAVES-1:0]                         m_axi_arvalid,
  input  logic [NUM_SLAVES-1:0]                         m_axi_arready,
  input  logic [NUM_SLAVES-1:0][AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [NUM_SLAVES-1:0][1:0]                    m_axi_rresp,
  input  logic [NUM_SLAVES-1:0]                         m_axi_rvalid,
  output logic [NUM_SLAVES-1:0]                         m_axi_rready
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  axi_dec_wr_state_e         wr_state, wr_state_n;
  axi_dec_rd_state_e         rd_state, rd_state_n;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [SEL_W-1:0]          wr_sel, rd_sel, aw_sel_d, ar_sel_d;
  logic                      aw_hit_d, ar_hit_d;
  logic                      aw_done, aw_done_n, w_done, w_done_n;
  logic                      live;

  // Decode the upstream address at the handshake; only the latched sel is used after.
  axi4lite_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES), .SEL_W(SEL_W),
    .SLAVE_BASE (SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK)
  ) u_wr_dec (.addr(s_axi_awaddr), .sel(aw_sel_d), .hit(aw_hit_d));

  axi4lite_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES), .SEL_W(SEL_W),
    .SLAVE_BASE (SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK)
  ) u_rd_dec (.addr(s_axi_araddr), .sel(ar_sel_d), .hit(ar_hit_d));

  // Addresses are broadcast; write data/strobe pass straight through.
  assign m_axi_awaddr = {NUM_SLAVES{aw_addr}};
  assign m_axi_araddr = {NUM_SLAVES{ar_addr}};
  assign m_axi_wdata  = {NUM_SLAVES{s_axi_wdata}};
  assign m_axi_wstrb  = {NUM_SLAVES{s_axi_wstrb}};

  // Holds the idle readys low while reset is asserted and for the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Write path state, latched address/select and AW/W completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      aw_addr  <= '0;
      wr_sel   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      wr_state <= wr_state_n;
      aw_done  <= aw_done_n;
      w_done   <= w_done_n;
      if (s_axi_awready && s_axi_awvalid) begin
        aw_addr <= s_axi_awaddr;
        wr_sel  <= aw_sel_d;
      end
    end
  end

  // Write next-state and handshake routing.
  always_comb begin
    wr_state_n    = wr_state;
    aw_done_n     = aw_done;
    w_done_n      = w_done;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = AXI_RESP_OKAY;
    m_axi_awvalid = '0;
    m_axi_wvalid  = '0;
    m_axi_bready  = '0;
    case (wr_state)
      WR_IDLE: begin
        s_axi_awready = live;
        if (live && s_axi_awvalid) wr_state_n = aw_hit_d ? WR_FWD : WR_ERR;
      end
      WR_FWD: begin
        m_axi_awvalid[wr_sel] = !aw_done;
        m_axi_wvalid[wr_sel]  = s_axi_wvalid && !w_done;
        s_axi_wready          = m_axi_wready[wr_sel] && !w_done;
        if (!aw_done && m_axi_awready[wr_sel]) aw_done_n = 1'b1;
        if (s_axi_wvalid && s_axi_wready)      w_done_n  = 1'b1;
        if (aw_done_n && w_done_n)             wr_state_n = WR_RESP;
      end
      WR_RESP: begin
        s_axi_bvalid         = m_axi_bvalid[wr_sel];
        s_axi_bresp          = m_axi_bresp[wr_sel];
        m_axi_bready[wr_sel] = s_axi_bready;
        if (s_axi_bvalid && s_axi_bready) begin
          wr_state_n = WR_IDLE;
          aw_done_n  = 1'b0;
          w_done_n   = 1'b0;
        end
      end
      WR_ERR: begin
        // Swallow the write beat, then answer DECERR without touching any slave.
        s_axi_wready = !w_done;
        if (s_axi_wvalid && !w_done) w_done_n = 1'b1;
        s_axi_bvalid = w_done;
        if (w_done) s_axi_bresp = AXI_RESP_DECERR;
        if (w_done && s_axi_bready) begin
          wr_state_n = WR_IDLE;
          w_done_n   = 1'b0;
        end
      end
      default: wr_state_n = WR_IDLE;
    endcase
  end

  // Read path state and latched address/select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      ar_addr  <= '0;
      rd_sel   <= '0;
    end else begin
      rd_state <= rd_state_n;
      if (s_axi_arready && s_axi_arvalid) begin
        ar_addr <= s_axi_araddr;
        rd_sel  <= ar_sel_d;
      end
    end
  end

  // Read next-state and response muxing.
  always_comb begin
    rd_state_n    = rd_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rdata   = '0;
    s_axi_rresp   = AXI_RESP_OKAY;
    m_axi_arvalid = '0;
    m_axi_rready  = '0;
    case (rd_state)
      RD_IDLE: begin
        s_axi_arready = live;
        if (live && s_axi_arvalid) rd_state_n = ar_hit_d ? RD_ADDR : RD_ERR;
      end
      RD_ADDR: begin
        m_axi_arvalid[rd_sel] = 1'b1;
        if (m_axi_arready[rd_sel]) rd_state_n = RD_DATA;
      end
      RD_DATA: begin
        s_axi_rvalid         = m_axi_rvalid[rd_sel];
        s_axi_rdata          = m_axi_rdata[rd_sel];
        s_axi_rresp          = m_axi_rresp[rd_sel];
        m_axi_rready[rd_sel] = s_axi_rready;
        if (s_axi_rvalid && s_axi_rready) rd_state_n = RD_IDLE;
      end
      RD_ERR: begin
        s_axi_rvalid = 1'b1;
        s_axi_rresp  = AXI_RESP_DECERR;
        if (s_axi_rready) rd_state_n = RD_IDLE;
      end
      default: rd_state_n = RD_IDLE;
    endcase
  end

endmodule
